// File: rtl/eva_cache_ctrl_pkg.sv
// Definitions shared by the EVA cache controller and the EVA replacement engine:
// line-index width, cache geometry, victim latency default and controller states.
package eva_cache_ctrl_pkg;

  localparam int LINE_W       = 5;
  localparam int LINES        = 32;
  localparam int VICT_LAT_DEF = 2;
  localparam int TAG_W_DEF    = 27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_VREQ,
    ST_VWAIT,
    ST_WB,
    ST_FILL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/eva_cache_ctrl_if.sv
// CPU request, replacement-engine event and memory-side signals of the cache
// controller; the controller owns the master modport.
interface eva_cache_ctrl_if #(parameter int TAG_W = eva_cache_ctrl_pkg::TAG_W_DEF);
  import eva_cache_ctrl_pkg::*;

  logic              cpu_req;
  logic              cpu_wr;
  logic [TAG_W-1:0]  cpu_tag;
  logic              cpu_ready;
  logic              cpu_done;
  logic              cpu_hit;
  logic [LINE_W-1:0] cpu_line;

  logic              re;
  logic              we;
  logic              hit;
  logic              miss;
  logic [LINE_W-1:0] access_addr;
  logic              EVA_en;
  logic [LINE_W-1:0] EVA_addr;

  logic              mem_req;
  logic              mem_wr;
  logic [TAG_W-1:0]  mem_tag;
  logic              mem_ack;

  modport master (
    input  cpu_req, cpu_wr, cpu_tag, EVA_addr, mem_ack,
    output cpu_ready, cpu_done, cpu_hit, cpu_line,
    output re, we, hit, miss, access_addr, EVA_en,
    output mem_req, mem_wr, mem_tag
  );

  modport slave (
    output cpu_req, cpu_wr, cpu_tag, EVA_addr, mem_ack,
    input  cpu_ready, cpu_done, cpu_hit, cpu_line,
    input  re, we, hit, miss, access_addr, EVA_en,
    input  mem_req, mem_wr, mem_tag
  );

endinterface

// File: rtl/eva_cache_ctrl_tag_match.sv
// Combinational 32-way tag compare with lowest-index priority for both the
// matching line and the first invalid line.
module eva_tag_match
  import eva_cache_ctrl_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic [TAG_W-1:0]  tag,
  input  logic [TAG_W-1:0]  tags [LINES],
  input  logic [LINES-1:0]  valid,
  output logic              hit_vld,
  output logic [LINE_W-1:0] hit_idx,
  output logic              free_vld,
  output logic [LINE_W-1:0] free_idx
);

  // Scanning from the top down lets the lowest index overwrite any higher one.
  always_comb begin
    hit_vld  = 1'b0;
    hit_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == tag)) begin
        hit_vld = 1'b1;
        hit_idx = LINE_W'(i);
      end
      if (!valid[i]) begin
        free_vld = 1'b1;
        free_idx = LINE_W'(i);
      end
    end
  end

endmodule

// File: rtl/eva_cache_ctrl.sv
// Lookup and miss-handling controller for the 32-line fully-associative cache:
// keeps tag/valid/dirty state, feeds the EVA engine, sequences writeback and fill.
module eva_cache_ctrl
  import eva_cache_ctrl_pkg::*;
#(
  parameter int TAG_W    = TAG_W_DEF,
  parameter int VICT_LAT = VICT_LAT_DEF
) (
  input logic              clk,
  input logic              rst,
  eva_cache_ctrl_if.master bus
);

  localparam logic [2:0] LAST_WAIT = 3'(VICT_LAT - 1);

  state_e            r_state;
  state_e            w_next;
  logic [TAG_W-1:0]  r_tag [LINES];
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_req_tag;
  logic              r_wr;
  logic              r_hit;
  logic [LINE_W-1:0] r_victim;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] r_access_addr;
  logic [2:0]        r_cnt;

  logic              w_hit_vld;
  logic [LINE_W-1:0] w_hit_idx;
  logic              w_free_vld;
  logic [LINE_W-1:0] w_free_idx;
  logic              w_vict_sample;

  eva_tag_match #(.TAG_W(TAG_W)) u_match (
    .tag      (r_req_tag),
    .tags     (r_tag),
    .valid    (r_valid),
    .hit_vld  (w_hit_vld),
    .hit_idx  (w_hit_idx),
    .free_vld (w_free_vld),
    .free_idx (w_free_idx)
  );

  assign w_vict_sample = (r_state == ST_VWAIT) && (r_cnt == LAST_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Every output is decoded from the state and registered data only, so
  // reset drives them all back to idle values without waiting for a clock.
  always_comb begin
    w_next          = r_state;
    bus.cpu_ready   = 1'b0;
    bus.cpu_done    = 1'b0;
    bus.cpu_hit     = 1'b0;
    bus.cpu_line    = '0;
    bus.re          = 1'b0;
    bus.we          = 1'b0;
    bus.hit         = 1'b0;
    bus.miss        = 1'b0;
    bus.access_addr = r_access_addr;
    bus.EVA_en      = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_tag     = '0;
    case (r_state)
      ST_IDLE: begin
        bus.cpu_ready = 1'b1;
        if (bus.cpu_req) w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        bus.re          = ~r_wr;
        bus.we          = r_wr;
        bus.hit         = w_hit_vld;
        bus.miss        = ~w_hit_vld;
        bus.access_addr = w_hit_vld ? w_hit_idx : '0;
        if (w_hit_vld)       w_next = ST_DONE;
        else if (w_free_vld) w_next = ST_FILL;
        else                 w_next = ST_VREQ;
      end
      ST_VREQ: begin
        bus.EVA_en = 1'b1;
        w_next     = ST_VWAIT;
      end
      ST_VWAIT: begin
        if (w_vict_sample) w_next = r_dirty[bus.EVA_addr] ? ST_WB : ST_FILL;
      end
      ST_WB: begin
        bus.mem_req = 1'b1;
        bus.mem_wr  = 1'b1;
        bus.mem_tag = r_tag[r_victim];
        if (bus.mem_ack) w_next = ST_FILL;
      end
      ST_FILL: begin
        bus.mem_req = 1'b1;
        bus.mem_tag = r_req_tag;
        if (bus.mem_ack) w_next = ST_DONE;
      end
      ST_DONE: begin
        // A serviced miss reports its fill to the engine alongside completion.
        bus.cpu_done = 1'b1;
        bus.cpu_hit  = r_hit;
        bus.cpu_line = r_line;
        bus.we       = ~r_hit;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINES; i++) r_tag[i] <= '0;
      r_valid       <= '0;
      r_dirty       <= '0;
      r_req_tag     <= '0;
      r_wr          <= 1'b0;
      r_hit         <= 1'b0;
      r_victim      <= '0;
      r_line        <= '0;
      r_access_addr <= '0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cpu_req) begin
            r_req_tag <= bus.cpu_tag;
            r_wr      <= bus.cpu_wr;
          end
        end
        ST_LOOKUP: begin
          r_hit <= w_hit_vld;
          if (w_hit_vld) begin
            r_line        <= w_hit_idx;
            r_access_addr <= w_hit_idx;
            if (r_wr) r_dirty[w_hit_idx] <= 1'b1;
          end else begin
            r_access_addr <= '0;
            r_victim      <= w_free_idx;
          end
        end
        ST_VREQ: r_cnt <= '0;
        ST_VWAIT: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_vict_sample) r_victim <= bus.EVA_addr;
        end
        ST_WB: begin
          if (bus.mem_ack) r_dirty[r_victim] <= 1'b0;
        end
        ST_FILL: begin
          if (bus.mem_ack) begin
            r_tag[r_victim]   <= r_req_tag;
            r_valid[r_victim] <= 1'b1;
            r_dirty[r_victim] <= r_wr;
            r_line            <= r_victim;
            r_access_addr     <= r_victim;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eva_cache_ctrl.sv
// Self-checking bench for eva_cache_ctrl: directed scenarios followed by a
// randomized run compared against a line-level model of the cache contents.
module tb_eva_cache_ctrl;
  import eva_cache_ctrl_pkg::*;

  localparam int TW      = 27;
  localparam int VL      = 2;
  localparam int MAX_CYC = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  eva_cache_ctrl_if #(.TAG_W(TW)) bus ();

  eva_cache_ctrl #(.TAG_W(TW), .VICT_LAT(VL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nChecks = 0;
  int nFail   = 0;

  logic [TW-1:0] mTag [32];
  bit            mValid [32];
  bit            mDirty [32];

  typedef struct {
    bit            timeout;
    bit            ready0;
    int            doneCyc;
    logic          cpuHit;
    logic [4:0]    cpuLine;
    int            nEvents;
    int            nLookup;
    logic          lkRe, lkWe, lkHit, lkMiss;
    logic [4:0]    lkAddr;
    int            nFill;
    logic [4:0]    fillAddr;
    int            nEva;
    bit            evaClash;
    int            nMem;
    logic [1:0]    memWr;
    logic [TW-1:0] memTag0, memTag1;
  } obs_t;

  typedef struct {
    bit            hit;
    logic [4:0]    line;
    bit            full;
    bit            wb;
    logic [TW-1:0] wbTag;
    int            doneCyc;
    int            nMem;
  } exp_t;

  // Reference: find the line by tag, else the first empty line, else the
  // engine's victim; latency is summed from the phases the request visits.
  task automatic model_access(input logic wr, input logic [TW-1:0] tag,
                              input logic [4:0] victim, input int memLat, output exp_t e);
    int idx = -1;
    int fr  = -1;
    e = '{default: 0};
    for (int i = 0; i < 32; i++) if (idx < 0 && mValid[i] && mTag[i] == tag) idx = i;
    if (idx >= 0) begin
      e.hit = 1; e.line = 5'(idx); e.doneCyc = 2; e.nMem = 0;
      if (wr) mDirty[idx] = 1;
    end else begin
      for (int i = 0; i < 32; i++) if (fr < 0 && !mValid[i]) fr = i;
      e.full  = (fr < 0);
      e.line  = e.full ? victim : 5'(fr);
      e.wb    = e.full && mDirty[e.line];
      e.wbTag = mTag[e.line];
      e.nMem  = e.wb ? 2 : 1;
      e.doneCyc = 2 + (e.full ? 1 + VL : 0) + (e.wb ? memLat + 1 : 0) + memLat + 1;
      mTag[e.line] = tag; mValid[e.line] = 1; mDirty[e.line] = wr;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_tag = '0; bus.mem_ack = 0; bus.EVA_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin mTag[i] = '0; mValid[i] = 0; mDirty[i] = 0; end
  endtask

  // Issues one request, plays memory (fixed latency) and the replacement
  // engine (EVA_addr valid only in the sampling cycle), and records what it saw.
  task automatic run_req(input logic wr, input logic [TW-1:0] tag, input logic [4:0] victim,
                         input int memLat, input bit holdReq, output obs_t o);
    int evaK = -1;
    int memCnt = 0;
    bit active = 0;
    o = '{default: 0};
    o.doneCyc = -1;
    o.timeout = 1;
    bus.EVA_addr = ~victim;
    @(negedge clk);
    o.ready0 = bus.cpu_ready;
    bus.cpu_req = 1; bus.cpu_wr = wr; bus.cpu_tag = tag;
    for (int k = 1; k <= MAX_CYC; k++) begin
      @(negedge clk);
      if (!holdReq) bus.cpu_req = 0;
      if (bus.hit || bus.miss) begin
        o.nLookup++;
        if (o.nLookup == 1) begin
          {o.lkRe, o.lkWe, o.lkHit, o.lkMiss} = {bus.re, bus.we, bus.hit, bus.miss};
          o.lkAddr = bus.access_addr;
        end
      end
      if (bus.re || bus.we || bus.hit || bus.miss) o.nEvents++;
      if (bus.we && !bus.hit && !bus.miss) begin o.nFill++; o.fillAddr = bus.access_addr; end
      if (bus.EVA_en) begin
        o.nEva++; evaK = k;
        if (bus.re || bus.we || bus.hit || bus.miss) o.evaClash = 1;
      end
      if (bus.mem_ack) begin bus.mem_ack = 0; active = 0; end
      if (bus.mem_req && !active) begin
        active = 1; memCnt = memLat;
        if (o.nMem == 0) begin o.memWr[0] = bus.mem_wr; o.memTag0 = bus.mem_tag; end
        if (o.nMem == 1) begin o.memWr[1] = bus.mem_wr; o.memTag1 = bus.mem_tag; end
        o.nMem++;
      end
      if (active) begin
        if (memCnt == 0) bus.mem_ack = 1;
        else memCnt--;
      end
      bus.EVA_addr = (evaK >= 0 && k == evaK + VL) ? victim : ~victim;
      if (bus.cpu_done) begin
        o.doneCyc = k; o.cpuHit = bus.cpu_hit; o.cpuLine = bus.cpu_line; o.timeout = 0;
        break;
      end
    end
    bus.cpu_req = 0;
    bus.mem_ack = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    #1;
    nChecks++; if ({bus.cpu_ready, bus.cpu_done, bus.cpu_hit, bus.re, bus.we, bus.hit, bus.miss, bus.EVA_en, bus.mem_req, bus.mem_wr} !== 10'b1000000000) begin nFail++; $display("[TB] FAIL reset_flags: got %b expected 1000000000", {bus.cpu_ready, bus.cpu_done, bus.cpu_hit, bus.re, bus.we, bus.hit, bus.miss, bus.EVA_en, bus.mem_req, bus.mem_wr}); end
    nChecks++; if ({bus.access_addr, bus.cpu_line} !== 10'd0 || bus.mem_tag !== '0) begin nFail++; $display("[TB] FAIL reset_buses: got addr=%0d line=%0d tag=%0h expected 0", bus.access_addr, bus.cpu_line, bus.mem_tag); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nChecks++; if (bus.cpu_ready !== 1'b1 || bus.mem_req !== 1'b0) begin nFail++; $display("[TB] FAIL reset_release_idle: got ready=%b mem_req=%b expected 1 0", bus.cpu_ready, bus.mem_req); end
  endtask

  task automatic test_miss_fill();
    obs_t o; exp_t e;
    model_access(0, 27'h10, 5'd0, 3, e);
    run_req(0, 27'h10, 5'd0, 3, 0, o);
    nChecks++; if (o.ready0 !== 1'b1 || o.timeout) begin nFail++; $display("[TB] FAIL miss_accept: got ready=%b timeout=%b expected 1 0", o.ready0, o.timeout); end
    nChecks++; if ({o.lkRe, o.lkWe, o.lkHit, o.lkMiss} !== 4'b1001 || o.lkAddr !== 5'd0) begin nFail++; $display("[TB] FAIL miss_lookup_event: got rwhm=%b addr=%0d expected 1001 0", {o.lkRe, o.lkWe, o.lkHit, o.lkMiss}, o.lkAddr); end
    nChecks++; if (o.nMem !== 1 || o.memWr[0] !== 1'b0 || o.memTag0 !== 27'h10) begin nFail++; $display("[TB] FAIL miss_mem_fill: got n=%0d wr=%b tag=%0h expected 1 0 10", o.nMem, o.memWr[0], o.memTag0); end
    nChecks++; if (o.nFill !== 1 || o.fillAddr !== 5'd0) begin nFail++; $display("[TB] FAIL miss_fill_event: got n=%0d addr=%0d expected 1 0", o.nFill, o.fillAddr); end
    nChecks++; if (o.cpuHit !== 1'b0 || o.cpuLine !== 5'd0 || o.nEva !== 0) begin nFail++; $display("[TB] FAIL miss_done: got hit=%b line=%0d eva=%0d expected 0 0 0", o.cpuHit, o.cpuLine, o.nEva); end
    nChecks++; if (o.doneCyc !== e.doneCyc) begin nFail++; $display("[TB] FAIL miss_latency: got %0d expected %0d", o.doneCyc, e.doneCyc); end
  endtask

  task automatic test_hit();
    obs_t o; exp_t e;
    model_access(0, 27'h10, 5'd0, 3, e);
    run_req(0, 27'h10, 5'd0, 3, 0, o);
    nChecks++; if (o.doneCyc !== 2) begin nFail++; $display("[TB] FAIL hit_latency: got %0d expected 2", o.doneCyc); end
    nChecks++; if (o.cpuHit !== 1'b1 || o.cpuLine !== 5'd0) begin nFail++; $display("[TB] FAIL hit_done: got hit=%b line=%0d expected 1 0", o.cpuHit, o.cpuLine); end
    nChecks++; if ({o.lkRe, o.lkWe, o.lkHit, o.lkMiss} !== 4'b1010 || o.nMem !== 0 || o.nFill !== 0) begin nFail++; $display("[TB] FAIL hit_events: got rwhm=%b mem=%0d fill=%0d expected 1010 0 0", {o.lkRe, o.lkWe, o.lkHit, o.lkMiss}, o.nMem, o.nFill); end
  endtask

  task automatic test_fill_all();
    obs_t o; exp_t e;
    int bad = 0;
    do_reset();
    for (int t = 0; t < 32; t++) begin
      model_access(0, TW'(t), 5'd0, 1, e);
      run_req(0, TW'(t), 5'd0, 1, 0, o);
      nChecks++; if (o.cpuLine !== e.line || o.cpuHit !== 1'b0 || o.nEva !== 0) begin nFail++; bad++; $display("[TB] FAIL fill_all_line: tag %0d got line=%0d hit=%b eva=%0d expected %0d 0 0", t, o.cpuLine, o.cpuHit, o.nEva, e.line); end
    end
    model_access(1, 27'd5, 5'd0, 1, e);
    run_req(1, 27'd5, 5'd0, 1, 0, o);
    nChecks++; if ({o.lkRe, o.lkWe, o.lkHit, o.lkMiss} !== 4'b0110 || o.lkAddr !== 5'd5) begin nFail++; $display("[TB] FAIL store_hit_event: got rwhm=%b addr=%0d expected 0110 5", {o.lkRe, o.lkWe, o.lkHit, o.lkMiss}, o.lkAddr); end
    nChecks++; if (o.doneCyc !== 2 || o.cpuLine !== 5'd5 || o.cpuHit !== 1'b1) begin nFail++; $display("[TB] FAIL store_hit_done: got cyc=%0d line=%0d hit=%b expected 2 5 1", o.doneCyc, o.cpuLine, o.cpuHit); end
  endtask

  task automatic test_dirty_evict();
    obs_t o; exp_t e;
    model_access(0, 27'd100, 5'd5, 2, e);
    run_req(0, 27'd100, 5'd5, 2, 0, o);
    nChecks++; if (o.nEva !== 1 || o.evaClash) begin nFail++; $display("[TB] FAIL dirty_eva_pulse: got n=%0d clash=%b expected 1 0", o.nEva, o.evaClash); end
    nChecks++; if (o.nMem !== 2 || o.memWr !== 2'b01 || o.memTag0 !== 27'd5 || o.memTag1 !== 27'd100) begin nFail++; $display("[TB] FAIL dirty_wb_then_fill: got n=%0d wr=%b tags=%0d,%0d expected 2 01 5,100", o.nMem, o.memWr, o.memTag0, o.memTag1); end
    nChecks++; if (o.fillAddr !== 5'd5 || o.cpuLine !== 5'd5 || o.cpuHit !== 1'b0 || o.lkMiss !== 1'b1) begin nFail++; $display("[TB] FAIL dirty_fill_line: got fill=%0d line=%0d hit=%b miss=%b expected 5 5 0 1", o.fillAddr, o.cpuLine, o.cpuHit, o.lkMiss); end
    nChecks++; if (o.doneCyc !== e.doneCyc) begin nFail++; $display("[TB] FAIL dirty_latency: got %0d expected %0d", o.doneCyc, e.doneCyc); end
    model_access(0, 27'd100, 5'd0, 2, e);
    run_req(0, 27'd100, 5'd0, 2, 0, o);
    nChecks++; if (o.cpuHit !== 1'b1 || o.cpuLine !== 5'd5) begin nFail++; $display("[TB] FAIL refill_hit: got hit=%b line=%0d expected 1 5", o.cpuHit, o.cpuLine); end
  endtask

  task automatic test_clean_evict();
    obs_t o; exp_t e;
    model_access(0, 27'd200, 5'd31, 1, e);
    run_req(0, 27'd200, 5'd31, 1, 0, o);
    nChecks++; if (o.nMem !== 1 || o.memWr[0] !== 1'b0 || o.memTag0 !== 27'd200) begin nFail++; $display("[TB] FAIL clean_no_wb: got n=%0d wr=%b tag=%0d expected 1 0 200", o.nMem, o.memWr[0], o.memTag0); end
    nChecks++; if (o.fillAddr !== 5'd31 || o.cpuLine !== 5'd31 || o.nEva !== 1) begin nFail++; $display("[TB] FAIL clean_fill_addr: got fill=%0d line=%0d eva=%0d expected 31 31 1", o.fillAddr, o.cpuLine, o.nEva); end
    nChecks++; if (o.doneCyc !== e.doneCyc) begin nFail++; $display("[TB] FAIL clean_latency: got %0d expected %0d", o.doneCyc, e.doneCyc); end
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e;
    do_reset();
    model_access(0, 27'h33, 5'd0, 1, e);
    run_req(0, 27'h33, 5'd0, 1, 0, o);
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_tag = 27'h44;
    for (int k = 0; k < 20 && !bus.mem_req; k++) @(negedge clk);
    bus.cpu_req = 0;
    nChecks++; if (bus.mem_req !== 1'b1) begin nFail++; $display("[TB] FAIL midreset_reach_fill: got mem_req=%b expected 1", bus.mem_req); end
    #2 rst = 1'b0;
    #1;
    nChecks++; if ({bus.cpu_ready, bus.mem_req, bus.cpu_done, bus.re, bus.we, bus.EVA_en} !== 6'b100000) begin nFail++; $display("[TB] FAIL midreset_async: got rdy/mreq/done/re/we/eva=%b expected 100000", {bus.cpu_ready, bus.mem_req, bus.cpu_done, bus.re, bus.we, bus.EVA_en}); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin mValid[i] = 0; mDirty[i] = 0; end
    model_access(0, 27'h33, 5'd0, 1, e);
    run_req(0, 27'h33, 5'd0, 1, 0, o);
    nChecks++; if (o.cpuHit !== e.hit || o.cpuLine !== e.line || o.nMem !== 1) begin nFail++; $display("[TB] FAIL midreset_invalidated: got hit=%b line=%0d mem=%0d expected %b %0d 1", o.cpuHit, o.cpuLine, o.nMem, e.hit, e.line); end
  endtask

  task automatic test_busy_req();
    obs_t o; exp_t e;
    int extra = 0;
    model_access(0, 27'h55, 5'd0, 4, e);
    run_req(0, 27'h55, 5'd0, 4, 1, o);
    nChecks++; if (o.nLookup !== 1 || o.nEvents !== 2 || o.nMem !== 1) begin nFail++; $display("[TB] FAIL busy_single_accept: got lookups=%0d events=%0d mem=%0d expected 1 2 1", o.nLookup, o.nEvents, o.nMem); end
    nChecks++; if (o.doneCyc !== e.doneCyc || o.cpuLine !== e.line) begin nFail++; $display("[TB] FAIL busy_done: got cyc=%0d line=%0d expected %0d %0d", o.doneCyc, o.cpuLine, e.doneCyc, e.line); end
    @(negedge clk);
    bus.mem_ack = 1;
    @(negedge clk);
    bus.mem_ack = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.re || bus.we || bus.hit || bus.miss || bus.mem_req || bus.cpu_done || bus.EVA_en || !bus.cpu_ready) extra++;
      @(negedge clk);
    end
    nChecks++; if (extra !== 0) begin nFail++; $display("[TB] FAIL spurious_ack_idle: got %0d active cycles expected 0", extra); end
    model_access(0, 27'h55, 5'd0, 1, e);
    run_req(0, 27'h55, 5'd0, 1, 0, o);
    nChecks++; if (o.cpuHit !== 1'b1 || o.cpuLine !== e.line) begin nFail++; $display("[TB] FAIL busy_followup_hit: got hit=%b line=%0d expected 1 %0d", o.cpuHit, o.cpuLine, e.line); end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic [TW-1:0] tag;
    logic wr;
    logic [4:0] vic;
    int lat;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      tag = TW'($urandom_range(0, 47));
      wr  = 1'($urandom_range(0, 1));
      vic = 5'($urandom_range(0, 31));
      lat = int'($urandom_range(0, 3));
      model_access(wr, tag, vic, lat, e);
      run_req(wr, tag, vic, lat, 0, o);
      nChecks++; if (o.timeout || o.cpuHit !== e.hit || o.cpuLine !== e.line) begin nFail++; $display("[TB] FAIL rand_result #%0d: got to=%b hit=%b line=%0d expected 0 %b %0d", n, o.timeout, o.cpuHit, o.cpuLine, e.hit, e.line); end
      nChecks++; if (o.doneCyc !== e.doneCyc || o.nMem !== e.nMem || o.nEva !== int'(e.full) || o.nLookup !== 1 || o.evaClash) begin nFail++; $display("[TB] FAIL rand_timing #%0d: got cyc=%0d mem=%0d eva=%0d lk=%0d clash=%b expected %0d %0d %0d 1 0", n, o.doneCyc, o.nMem, o.nEva, o.nLookup, o.evaClash, e.doneCyc, e.nMem, e.full); end
      if (e.wb) begin
        nChecks++; if (o.memWr !== 2'b01 || o.memTag0 !== e.wbTag || o.memTag1 !== tag) begin nFail++; $display("[TB] FAIL rand_writeback #%0d: got wr=%b tags=%0d,%0d expected 01 %0d,%0d", n, o.memWr, o.memTag0, o.memTag1, e.wbTag, tag); end
      end else if (!e.hit) begin
        nChecks++; if (o.memWr[0] !== 1'b0 || o.memTag0 !== tag || o.fillAddr !== e.line) begin nFail++; $display("[TB] FAIL rand_fill #%0d: got wr=%b tag=%0d fill=%0d expected 0 %0d %0d", n, o.memWr[0], o.memTag0, o.fillAddr, tag, e.line); end
      end
    end
  endtask

  initial begin
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_tag = '0; bus.mem_ack = 0; bus.EVA_addr = '0;
    test_reset();
    test_miss_fill();
    test_hit();
    test_fill_all();
    test_dirty_evict();
    test_clean_evict();
    test_reset_mid();
    test_busy_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
